// File: rtl/render_frame_controller_if.sv
// Signal bundle between the frame controller and its environment: register-file config,
// control pulses, the observed pixel handshake, and the shadowed/status outputs.
interface render_frame_controller_if #(
  parameter int FCNT_W = 16
);
  logic [10:0]       cfg_cam_pos_x, cfg_cam_pos_y, cfg_cam_pos_z;
  logic [10:0]       cfg_cam_dir_x, cfg_cam_dir_y, cfg_cam_dir_z;
  logic [12:0]       cfg_width, cfg_height;
  logic [31:0]       cfg_distance;
  logic              ctrl_start, ctrl_continuous, ctrl_abort;
  logic              pix_valid, pix_ready, pix_eol, pix_sof;

  logic              rt_resetn;
  logic [10:0]       rt_cam_pos_x, rt_cam_pos_y, rt_cam_pos_z;
  logic [10:0]       rt_cam_dir_x, rt_cam_dir_y, rt_cam_dir_z;
  logic [12:0]       rt_width, rt_height;
  logic [31:0]       rt_distance;
  logic              busy, frame_done;
  logic [FCNT_W-1:0] frame_count;
  logic              err_cfg, err_timeout, err_sof, err_geom;

  modport master (
    output cfg_cam_pos_x, cfg_cam_pos_y, cfg_cam_pos_z,
    output cfg_cam_dir_x, cfg_cam_dir_y, cfg_cam_dir_z,
    output cfg_width, cfg_height, cfg_distance,
    output ctrl_start, ctrl_continuous, ctrl_abort,
    output pix_valid, pix_ready, pix_eol, pix_sof,
    input  rt_resetn,
    input  rt_cam_pos_x, rt_cam_pos_y, rt_cam_pos_z,
    input  rt_cam_dir_x, rt_cam_dir_y, rt_cam_dir_z,
    input  rt_width, rt_height, rt_distance,
    input  busy, frame_done, frame_count,
    input  err_cfg, err_timeout, err_sof, err_geom
  );

  modport slave (
    input  cfg_cam_pos_x, cfg_cam_pos_y, cfg_cam_pos_z,
    input  cfg_cam_dir_x, cfg_cam_dir_y, cfg_cam_dir_z,
    input  cfg_width, cfg_height, cfg_distance,
    input  ctrl_start, ctrl_continuous, ctrl_abort,
    input  pix_valid, pix_ready, pix_eol, pix_sof,
    output rt_resetn,
    output rt_cam_pos_x, rt_cam_pos_y, rt_cam_pos_z,
    output rt_cam_dir_x, rt_cam_dir_y, rt_cam_dir_z,
    output rt_width, rt_height, rt_distance,
    output busy, frame_done, frame_count,
    output err_cfg, err_timeout, err_sof, err_geom
  );
endinterface

// File: rtl/render_frame_controller.sv
// Frame sequencer for the ray tracer: shadows camera/image config once per frame, holds the
// tracer in reset between frames, and watches the pixel stream for geometry/SOF/stall errors.
module render_frame_controller #(
  parameter int MAX_WIDTH      = 640,
  parameter int MAX_HEIGHT     = 480,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int FCNT_W         = 16
) (
  input logic                      aclk,
  input logic                      aresetn,
  render_frame_controller_if.slave bus
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [10:0] posX;
    logic [10:0] posY;
    logic [10:0] posZ;
    logic [10:0] dirX;
    logic [10:0] dirY;
    logic [10:0] dirZ;
    logic [12:0] width;
    logic [12:0] height;
    logic [31:0] distance;
  } frame_cfg_t;

  state_e            state_q, state_d;
  frame_cfg_t        shadow_q, shadow_d;
  frame_cfg_t        cfgIn;
  logic [12:0]       col_q, col_d;
  logic [12:0]       row_q, row_d;
  logic [WD_W-1:0]   watchdog_q, watchdog_d;
  logic              firstBeat_q, firstBeat_d;
  logic [FCNT_W-1:0] frameCount_q, frameCount_d;
  logic              errCfg_q, errCfg_d;
  logic              errTimeout_q, errTimeout_d;
  logic              errSof_q, errSof_d;
  logic              errGeom_q, errGeom_d;

  logic              beat;
  logic              cfgOk;
  logic              atLastCol;
  logic              atLastRow;
  logic              stallExpired;
  logic [WD_W-1:0]   watchdogInc;
  logic              rtResetn;
  logic              busyOut;
  logic              frameDone;

  assign beat         = bus.pix_valid & bus.pix_ready;
  assign cfgOk        = (bus.cfg_width  != 13'd0) && (bus.cfg_width  <= 13'(MAX_WIDTH)) &&
                        (bus.cfg_height != 13'd0) && (bus.cfg_height <= 13'(MAX_HEIGHT));
  assign atLastCol    = (col_q == shadow_q.width  - 13'd1);
  assign atLastRow    = (row_q == shadow_q.height - 13'd1);
  assign watchdogInc  = watchdog_q + WD_W'(1);
  assign stallExpired = !beat && (watchdogInc == WD_W'(TIMEOUT_CYCLES));

  always_comb begin
    cfgIn.posX     = bus.cfg_cam_pos_x;
    cfgIn.posY     = bus.cfg_cam_pos_y;
    cfgIn.posZ     = bus.cfg_cam_pos_z;
    cfgIn.dirX     = bus.cfg_cam_dir_x;
    cfgIn.dirY     = bus.cfg_cam_dir_y;
    cfgIn.dirZ     = bus.cfg_cam_dir_z;
    cfgIn.width    = bus.cfg_width;
    cfgIn.height   = bus.cfg_height;
    cfgIn.distance = bus.cfg_distance;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort wins over everything in LOAD/RUN/DONE, including a frame-completing eol beat.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.ctrl_start && cfgOk) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = bus.ctrl_abort ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        if (bus.ctrl_abort) begin
          state_d = ST_IDLE;
        end else if (beat && bus.pix_eol && atLastRow) begin
          state_d = ST_DONE;
        end else if (stallExpired) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        state_d = (bus.ctrl_continuous && !bus.ctrl_abort) ? ST_LOAD : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rtResetn  = (state_q == ST_RUN);
    busyOut   = (state_q != ST_IDLE);
    frameDone = (state_q == ST_DONE);
  end

  always_comb begin
    shadow_d     = shadow_q;
    col_d        = col_q;
    row_d        = row_q;
    watchdog_d   = watchdog_q;
    firstBeat_d  = firstBeat_q;
    frameCount_d = frameCount_q;
    errCfg_d     = errCfg_q;
    errTimeout_d = errTimeout_q;
    errSof_d     = errSof_q;
    errGeom_d    = errGeom_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.ctrl_start) begin
          errCfg_d     = !cfgOk;
          errTimeout_d = 1'b0;
          errSof_d     = 1'b0;
          errGeom_d    = 1'b0;
        end
      end
      ST_LOAD: begin
        shadow_d    = cfgIn;
        col_d       = 13'd0;
        row_d       = 13'd0;
        watchdog_d  = '0;
        firstBeat_d = 1'b1;
      end
      ST_RUN: begin
        if (!bus.ctrl_abort) begin
          if (beat) begin
            watchdog_d  = '0;
            firstBeat_d = 1'b0;
            if (firstBeat_q && !bus.pix_sof) begin
              errSof_d = 1'b1;
            end
            if (bus.pix_eol) begin
              if (!atLastCol) begin
                errGeom_d = 1'b1;
              end
              col_d = 13'd0;
              row_d = row_q + 13'd1;
            end else begin
              if (atLastCol) begin
                errGeom_d = 1'b1;
              end
              if (col_q != 13'h1FFF) begin
                col_d = col_q + 13'd1;
              end
            end
          end else begin
            watchdog_d = watchdogInc;
            if (stallExpired) begin
              errTimeout_d = 1'b1;
            end
          end
        end
      end
      ST_DONE: begin
        frameCount_d = frameCount_q + FCNT_W'(1);
      end
      default: ;
    endcase
  end

  // Reset release is assumed to be synchronised to aclk by the surrounding reset tree.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      shadow_q     <= '0;
      col_q        <= 13'd0;
      row_q        <= 13'd0;
      watchdog_q   <= '0;
      firstBeat_q  <= 1'b0;
      frameCount_q <= '0;
      errCfg_q     <= 1'b0;
      errTimeout_q <= 1'b0;
      errSof_q     <= 1'b0;
      errGeom_q    <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      col_q        <= col_d;
      row_q        <= row_d;
      watchdog_q   <= watchdog_d;
      firstBeat_q  <= firstBeat_d;
      frameCount_q <= frameCount_d;
      errCfg_q     <= errCfg_d;
      errTimeout_q <= errTimeout_d;
      errSof_q     <= errSof_d;
      errGeom_q    <= errGeom_d;
    end
  end

  assign bus.rt_resetn    = rtResetn;
  assign bus.busy         = busyOut;
  assign bus.frame_done   = frameDone;
  assign bus.rt_cam_pos_x = shadow_q.posX;
  assign bus.rt_cam_pos_y = shadow_q.posY;
  assign bus.rt_cam_pos_z = shadow_q.posZ;
  assign bus.rt_cam_dir_x = shadow_q.dirX;
  assign bus.rt_cam_dir_y = shadow_q.dirY;
  assign bus.rt_cam_dir_z = shadow_q.dirZ;
  assign bus.rt_width     = shadow_q.width;
  assign bus.rt_height    = shadow_q.height;
  assign bus.rt_distance  = shadow_q.distance;
  assign bus.frame_count  = frameCount_q;
  assign bus.err_cfg      = errCfg_q;
  assign bus.err_timeout  = errTimeout_q;
  assign bus.err_sof      = errSof_q;
  assign bus.err_geom     = errGeom_q;

endmodule
